// File: rtl/prpg_multi.sv
// prpg_multi: Galois LFSR pattern generator (PRPG) / multiple-input signature
// register (MISR) with load, period detection and optional all-zero recovery.
// Optional feature macro: PRPG_LOCKUP_RECOVER_EN (all-zero lockup recovery).
module prpg_multi #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  input  logic             En,
  input  logic             Mode,
  output logic [WIDTH-1:0] Dout,
  output logic             Valid,
  output logic             Period_done,
  output logic             Lockup
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_seed_q, ref_seed_d;
  logic             valid_q, valid_d;
  logic             period_done_q, period_done_d;
  logic [WIDTH-1:0] stepped;
`ifdef PRPG_LOCKUP_RECOVER_EN
  logic             lockup_q, lockup_d;
`endif

  // One Galois LFSR step: shift right, fold the taps back in when a one falls out.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] shifted;
    shifted = s >> 1;
    return s[0] ? (shifted ^ TAPS) : shifted;
  endfunction

  // Next-state selection: Load beats En; Mode picks generate vs. compress.
  always_comb begin
    state_d       = state_q;
    ref_seed_d    = ref_seed_q;
    valid_d       = 1'b0;
    period_done_d = 1'b0;
    stepped       = lfsr_step(state_q);
`ifdef PRPG_LOCKUP_RECOVER_EN
    lockup_d      = 1'b0;
`endif
    if (Load) begin
      valid_d = 1'b1;
`ifdef PRPG_LOCKUP_RECOVER_EN
      // A zero seed in generate mode would lock the LFSR; substitute SEED.
      if ((Din == '0) && !Mode) begin
        state_d    = SEED;
        ref_seed_d = SEED;
        lockup_d   = 1'b1;
      end else
`endif
      begin
        state_d    = Din;
        ref_seed_d = Din;
      end
    end else if (En) begin
      valid_d = 1'b1;
      if (Mode) begin
        // MISR: compress Din into the stepped state; never flags a period.
        state_d = stepped ^ Din;
      end else begin
`ifdef PRPG_LOCKUP_RECOVER_EN
        if (state_q == '0) begin
          state_d  = SEED;
          lockup_d = 1'b1;
        end else
`endif
        begin
          state_d       = stepped;
          period_done_d = (stepped == ref_seed_q);
        end
      end
    end
  end

  // State, reference seed and status flags; reset returns everything to SEED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SEED;
      ref_seed_q    <= SEED;
      valid_q       <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ref_seed_q    <= ref_seed_d;
      valid_q       <= valid_d;
      period_done_q <= period_done_d;
    end
  end

`ifdef PRPG_LOCKUP_RECOVER_EN
  // Lockup pulse register, present only when recovery is built in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lockup_q <= 1'b0;
    else     lockup_q <= lockup_d;
  end
  assign Lockup = lockup_q;
`else
  assign Lockup = 1'b0;
`endif

  assign Dout        = state_q;
  assign Valid       = valid_q;
  assign Period_done = period_done_q;

endmodule

// File: tb/tb_prpg_multi.sv
// Directed bench for prpg_multi at WIDTH=8, TAPS=B8, SEED=01.
module tb_prpg_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Load = 1'b0;
  logic [7:0] Din = 8'h00;
  logic       En = 1'b0;
  logic       Mode = 1'b0;
  logic [7:0] Dout;
  logic       Valid;
  logic       Period_done;
  logic       Lockup;

  int total = 0;
  int bad   = 0;

  prpg_multi #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01)) dut (
    .clk(clk), .rst(rst), .Load(Load), .Din(Din), .En(En), .Mode(Mode),
    .Dout(Dout), .Valid(Valid), .Period_done(Period_done), .Lockup(Lockup)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, settle just after it.
  task automatic tick(input logic ld, input logic en, input logic md, input logic [7:0] d);
    Load = ld; En = en; Mode = md; Din = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_step(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  logic [7:0] seq_exp [5] = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

  initial begin
    bit         seen [256];
    int         pd_count, pd_index, dups, zeros, model_err;
    logic [7:0] model;

    // Reset
    #2 rst = 1'b1;
    #1;
    check_val("rst_dout", Dout, 8'h01);
    check_val("rst_valid", Valid, 1'b0);
    check_val("rst_pd", Period_done, 1'b0);
    check_val("rst_lockup", Lockup, 1'b0);
    // Load ignored under reset
    tick(1'b1, 1'b1, 1'b0, 8'h77);
    check_val("rst_ignores_load", Dout, 8'h01);
    @(negedge clk);
    rst = 1'b0;

    // Basic generate sequence from SEED
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      check_val($sformatf("gen_seq%0d", i), Dout, seq_exp[i]);
      check_val($sformatf("gen_valid%0d", i), Valid, 1'b1);
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    check_val("hold_dout", Dout, 8'hB3);
    check_val("hold_valid", Valid, 1'b0);

    // Full period from loaded seed 01
    tick(1'b1, 1'b0, 1'b0, 8'h01);
    check_val("load01_dout", Dout, 8'h01);
    check_val("load01_pd", Period_done, 1'b0);
    pd_count = 0; pd_index = -1; dups = 0; zeros = 0; model_err = 0;
    model = 8'h01;
    for (int i = 1; i <= 255; i++) begin
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      model = ref_step(model);
      if (Dout !== model) model_err++;
      if (Dout == 8'h00) zeros++;
      if (seen[Dout]) dups++;
      seen[Dout] = 1'b1;
      if (Period_done) begin
        pd_count++;
        pd_index = i;
      end
    end
    check_val("period_model", model_err, 0);
    check_val("period_pd_count", pd_count, 1);
    check_val("period_pd_index", pd_index, 255);
    check_val("period_dups", dups, 0);
    check_val("period_zeros", zeros, 0);
    check_val("period_end_dout", Dout, 8'h01);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    check_val("period_pd_drop", Period_done, 1'b0);
    check_val("period_wrap", Dout, 8'hB8);

    // MISR compression
    tick(1'b1, 1'b0, 1'b1, 8'h00);
    check_val("misr_load", Dout, 8'h00);
    tick(1'b0, 1'b1, 1'b1, 8'h5A);
    check_val("misr_a", Dout, 8'h5A);
    check_val("misr_a_pd", Period_done, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 8'h00);
    check_val("misr_b", Dout, 8'h2D);
    check_val("misr_b_pd", Period_done, 1'b0);

    // Load wins over En
    tick(1'b1, 1'b1, 1'b0, 8'h3C);
    check_val("load_prio", Dout, 8'h3C);
    check_val("load_prio_valid", Valid, 1'b1);

    // All-zero lockup behaviour
    tick(1'b1, 1'b0, 1'b0, 8'h01);
    tick(1'b0, 1'b1, 1'b1, 8'hB8);
    check_val("lock_zero", Dout, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
`ifdef PRPG_LOCKUP_RECOVER_EN
    check_val("lock_recover", Dout, 8'h01);
    check_val("lock_pulse", Lockup, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    check_val("lock_pulse_end", Lockup, 1'b0);
`else
    check_val("lock_stuck", Dout, 8'h00);
    check_val("lock_tied", Lockup, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    check_val("lock_stuck2", Dout, 8'h00);
`endif

    // Asynchronous reset between edges
    tick(1'b1, 1'b0, 1'b0, 8'h01);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    check_val("async_pre", Dout, 8'h5C);
    #1 rst = 1'b1;
    #1;
    check_val("async_dout", Dout, 8'h01);
    check_val("async_valid", Valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    check_val("async_next", Dout, 8'hB8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prpg_multi.md
PRPG_MULTI -- requirements
Module: prpg_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 8: LFSR/state width, legal 4..32.
REQ-002 SHALL have parameter TAPS, default 8'hB8: Galois feedback mask (WIDTH bits).
REQ-003 SHALL have parameter SEED, default 8'h01: reset/recovery state (WIDTH bits, nonzero).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port Load  input  1  load Din into state.
REQ-007 SHALL have port Din  input  WIDTH  seed value on Load; compression data in MISR mode.
REQ-008 SHALL have port En  input  1  advance state one step.
REQ-009 SHALL have port Mode  input  1  0 = PRPG (generate), 1 = MISR (compress Din).
REQ-010 SHALL have port Dout  output  WIDTH  current state, registered.
REQ-011 SHALL have port Valid  output  1  high the cycle after any load or advance.
REQ-012 SHALL have port Period_done  output  1  one-cycle pulse when state returns to last-loaded seed.
REQ-013 SHALL have port Lockup  output  1  one-cycle pulse on all-zero recovery.

Function
REQ-014 Step function g(s) SHALL be: s>>1 if s[0]=0, else (s>>1)^TAPS.
REQ-015 Priority per edge SHALL be rst > Load > En; En ignored while Load=1.
REQ-016 Load SHALL set state=Din, ref_seed=Din, step counter=0, independent of Mode; Dout updates next edge (1-cycle latency).
REQ-017 En=1, Mode=0 SHALL set state=g(state).
REQ-018 En=1, Mode=1 SHALL set state=g(state)^Din.
REQ-019 En=0 and Load=0 SHALL hold state; Valid=0 next cycle.
REQ-020 Valid SHALL be registered: 1 in cycle following any edge with Load=1 or En=1.
REQ-021 Period_done SHALL pulse 1 cycle when an En=1, Mode=0 advance produces state==ref_seed; for WIDTH=8, TAPS=B8 this is 255 advances after load.
REQ-022 Mode SHALL be changeable any cycle; step uses Mode value sampled at that edge.
REQ-023 Period_done SHALL NOT assert on Load or on Mode=1 advances.
REQ-024 Dout SHALL equal state at all times (no combinational path from inputs).

Reset
REQ-025 rst=1 SHALL immediately set state=SEED, ref_seed=SEED, Dout=SEED, Valid=0, Period_done=0, Lockup=0.
REQ-026 rst asserted mid-sequence SHALL abandon the sequence; first advance after release yields g(SEED).
REQ-027 Load/En SHALL be ignored while rst=1.

Configuration
REQ-028 Macro PRPG_LOCKUP_RECOVER_EN SHALL control all-zero recovery.
REQ-029 Defined: En=1, Mode=0, state==0 SHALL load SEED and pulse Lockup; Load with Din=0 and Mode=0 SHALL load SEED instead, pulsing Lockup.
REQ-030 Not defined: state 0 SHALL persist under Mode=0 advances (g(0)=0); Lockup SHALL be tied 0.

Verification (WIDTH=8, TAPS=B8, SEED=01)
REQ-031 rst pulse, then En=1 Mode=0 five cycles -> Dout 01,B8,5C,2E,17,B3; Valid=1 from first advance.
REQ-032 Load=1 Din=01, then En=1 Mode=0 continuous -> Period_done single pulse when Dout returns to 01 after exactly 255 advances; all 255 states distinct, never 00.
REQ-033 Load Din=00 Mode=1, En=1 with Din=5A then Din=00 -> Dout 5A then 2D; Period_done stays 0.
REQ-034 Load=1 and En=1 same edge with Din=3C -> Dout=3C (no advance).
REQ-035 Macro defined: Load 01, Mode=1 En=1 Din=B8 -> Dout 00; then Mode=0 En=1 -> Dout 01, Lockup one-cycle pulse. Macro undefined: same stimulus -> Dout stays 00, Lockup 0.
REQ-036 rst asserted mid-advance between clock edges -> Dout=01 immediately, Valid=0, next advance -> B8.
